// File: rtl/bdm_command_sequencer_if.sv
// Host command/response and BDC serial-engine signals of the BDM command sequencer.
// master: host + serial-engine side; slave: the sequencer itself.
interface bdm_command_sequencer_if #(
    parameter int OPW = 3
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [OPW-1:0]  cmd_op;
    logic [7:0]      cmd_opcode;
    logic [15:0]     cmd_addr;
    logic [15:0]     cmd_wdata;
    logic            rsp_valid;
    logic [15:0]     rsp_data;
    logic            rsp_err;
    logic            busy;
    logic            tgt_clk_pulse;
    logic [7:0]      bdc_data_in;
    logic            bdc_send_data;
    logic            bdc_read_data;
    logic [7:0]      bdc_data_out;
    logic            bdc_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_opcode, cmd_addr, cmd_wdata,
        output tgt_clk_pulse, bdc_data_out, bdc_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        input  bdc_data_in, bdc_send_data, bdc_read_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_opcode, cmd_addr, cmd_wdata,
        input  tgt_clk_pulse, bdc_data_out, bdc_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        output bdc_data_in, bdc_send_data, bdc_read_data
    );
endinterface

// File: rtl/bdm_command_sequencer.sv
// BDM command sequencer: turns one host command into opcode/address/data byte
// transfers on the BDC serial engine, waits the target-clock no-ACK delay,
// collects read-back bytes and returns a single response.
module bdm_command_sequencer #(
    parameter int DELAY_TCLKS = 16,
    parameter int OPW         = 3
) (
    input logic                    clk,
    input logic                    rst,
    bdm_command_sequencer_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TX_REQ  = 3'd1;
    localparam logic [2:0] S_TX_WAIT = 3'd2;
    localparam logic [2:0] S_DELAY   = 3'd3;
    localparam logic [2:0] S_RX_REQ  = 3'd4;
    localparam logic [2:0] S_RX_WAIT = 3'd5;
    localparam logic [2:0] S_RESP    = 3'd6;

    localparam logic [OPW-1:0] OP_NODATA  = OPW'(0);
    localparam logic [OPW-1:0] OP_READ8   = OPW'(1);
    localparam logic [OPW-1:0] OP_WRITE8  = OPW'(2);
    localparam logic [OPW-1:0] OP_READ16  = OPW'(3);
    localparam logic [OPW-1:0] OP_WRITE16 = OPW'(4);

    localparam logic [7:0] DLY_INIT = 8'(DELAY_TCLKS);

    logic [2:0]       state;
    logic [3:0][7:0]  tx_buf;     // bytes to transmit, index 0 first
    logic [1:0]       tx_last;    // index of the final byte in tx_buf
    logic [1:0]       tx_idx;
    logic [1:0]       rx_left;
    logic [7:0]       dly_cnt;
    logic             guard;      // engine's ready is not trusted right after a strobe
    logic [15:0]      rsp_data_q;
    logic             rsp_err_q;
    logic             send_q;
    logic             read_q;
    logic [7:0]       data_in_q;
    logic             op_legal;

    assign op_legal = (bus.cmd_op <= OP_WRITE16);

    assign bus.cmd_ready     = (state == S_IDLE);
    assign bus.busy          = (state != S_IDLE);
    assign bus.rsp_valid     = (state == S_RESP);
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.bdc_send_data = send_q;
    assign bus.bdc_read_data = read_q;
    assign bus.bdc_data_in   = data_in_q;

    // Command sequencing FSM with its byte buffer, delay counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tx_buf     <= '0;
            tx_last    <= '0;
            tx_idx     <= '0;
            rx_left    <= '0;
            dly_cnt    <= '0;
            guard      <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            send_q     <= 1'b0;
            read_q     <= 1'b0;
            data_in_q  <= '0;
        end else begin
            // strobes are single-cycle unless re-armed below
            send_q <= 1'b0;
            read_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= ~op_legal;
                        tx_idx     <= '0;
                        tx_buf[0]  <= bus.cmd_opcode;
                        tx_last    <= 2'd0;
                        rx_left    <= 2'd0;
                        case (bus.cmd_op)
                            OP_READ8: begin
                                tx_buf[1] <= bus.cmd_addr[15:8];
                                tx_buf[2] <= bus.cmd_addr[7:0];
                                tx_last   <= 2'd2;
                                rx_left   <= 2'd1;
                            end
                            OP_WRITE8: begin
                                tx_buf[1] <= bus.cmd_addr[15:8];
                                tx_buf[2] <= bus.cmd_addr[7:0];
                                tx_buf[3] <= bus.cmd_wdata[7:0];
                                tx_last   <= 2'd3;
                            end
                            OP_READ16: rx_left <= 2'd2;
                            OP_WRITE16: begin
                                tx_buf[1] <= bus.cmd_wdata[15:8];
                                tx_buf[2] <= bus.cmd_wdata[7:0];
                                tx_last   <= 2'd2;
                            end
                            default: ;
                        endcase
                        // illegal ops answer immediately without touching the engine
                        state <= op_legal ? S_TX_REQ : S_RESP;
                    end
                end
                S_TX_REQ: begin
                    if (bus.bdc_ready) begin
                        data_in_q <= tx_buf[tx_idx];
                        send_q    <= 1'b1;
                        guard     <= 1'b1;
                        state     <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (bus.bdc_ready) begin
                        if (tx_idx != tx_last) begin
                            tx_idx <= tx_idx + 2'd1;
                            state  <= S_TX_REQ;
                        end else begin
                            dly_cnt <= DLY_INIT;
                            state   <= S_DELAY;
                        end
                    end
                end
                S_DELAY: begin
                    if (dly_cnt == 8'd0) begin
                        state <= (rx_left != 2'd0) ? S_RX_REQ : S_RESP;
                    end else if (bus.tgt_clk_pulse) begin
                        dly_cnt <= dly_cnt - 8'd1;
                    end
                end
                S_RX_REQ: begin
                    if (bus.bdc_ready) begin
                        read_q <= 1'b1;
                        guard  <= 1'b1;
                        state  <= S_RX_WAIT;
                    end
                end
                S_RX_WAIT: begin
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (bus.bdc_ready) begin
                        rsp_data_q <= {rsp_data_q[7:0], bus.bdc_data_out};
                        rx_left    <= rx_left - 2'd1;
                        state      <= (rx_left == 2'd1) ? S_RESP : S_RX_REQ;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bdm_command_sequencer.sv
// Self-checking bench for bdm_command_sequencer: a randomized serial-engine and
// target-clock model, an abstract per-command reference (expected byte list,
// read count, delay in target clocks, response value) checked every cycle, plus
// directed commands with literal expectations.
module tb_bdm_command_sequencer;

    localparam int DLY = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bdm_command_sequencer_if #(.OPW(3)) bus ();

    bdm_command_sequencer #(.DELAY_TCLKS(DLY), .OPW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // serial engine model
    int         eng_busy = 0;
    logic [7:0] forced_rx[$];
    logic [7:0] rx_log[$];

    // reference model state (owned by the compare process)
    logic [7:0] exp_tx[$];
    logic [7:0] tx_log[$];
    int         pending = 0, exp_rx_left = 0, exp_rx_total = 0, exp_op = 0;
    logic       exp_err = 1'b0;
    int         sent_any = 0, delay_started = 0, dpulses = 0, last_pulse_cyc = 0;
    int         acc_cyc = 0, cyc = 0, was_rst = 0, read_cnt = 0, rsp_count = 0;
    logic       prev_send = 1'b0, prev_read = 1'b0;
    logic [7:0] prev_data_in = 8'h00;
    logic [15:0] held_rsp = 16'h0000, last_rsp_data = 16'h0000, exp_data;
    logic       last_rsp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] next_rx();
        logic [7:0] b;
        if (forced_rx.size() > 0) b = forced_rx.pop_front();
        else b = 8'($urandom);
        rx_log.push_back(b);
        return b;
    endfunction

    assign bus.bdc_ready = (eng_busy == 0) && !bus.bdc_send_data && !bus.bdc_read_data;

    // engine: busy for 1..4 cycles per strobe, returns a byte per read; random target clocks
    always @(posedge clk) begin
        if (rst) begin
            eng_busy         <= 0;
            bus.bdc_data_out <= 8'h00;
        end else if (bus.bdc_send_data || bus.bdc_read_data) begin
            eng_busy <= $urandom_range(1, 4);
            if (bus.bdc_read_data) bus.bdc_data_out <= next_rx();
        end else if (eng_busy > 0) begin
            eng_busy <= eng_busy - 1;
        end
        bus.tgt_clk_pulse <= !rst && ($urandom_range(0, 2) == 0);
    end

    // compare process: every cycle, outputs against the abstract command model
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pending = 0; exp_tx.delete(); exp_rx_left = 0; was_rst = 1;
                held_rsp = 16'h0; prev_data_in = 8'h0; prev_send = 0; prev_read = 0;
                delay_started = 0;
                continue;
            end
            if (was_rst != 0) begin
                chk("reset_outputs",
                    32'({bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_err, bus.bdc_send_data,
                         bus.bdc_read_data, bus.bdc_data_in, bus.rsp_data}),
                    32'h2000_0000);
                was_rst = 0;
            end
            chk("ready_busy", {30'b0, bus.cmd_ready, bus.busy}, (pending != 0) ? 32'd1 : 32'd2);
            if (bus.bdc_send_data || bus.bdc_read_data)
                chk("strobe_overlap", 32'(bus.bdc_send_data && bus.bdc_read_data), 0);
            // delay bookkeeping: pulses after the cycle the last byte completes
            if (pending != 0 && delay_started != 0 && bus.tgt_clk_pulse && dpulses < DLY) begin
                dpulses++;
                last_pulse_cyc = cyc;
            end
            if (pending != 0 && !exp_err && sent_any != 0 && exp_tx.size() == 0 && delay_started == 0
                && !bus.bdc_send_data && !prev_send && eng_busy == 0)
                delay_started = 1;
            if (bus.bdc_send_data) begin
                chk("send_engine_idle", eng_busy, 0);
                chk("send_one_cycle", 32'(prev_send), 0);
                chk("send_expected", 32'(pending != 0 && exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) chk("send_byte", 32'(bus.bdc_data_in), 32'(exp_tx.pop_front()));
                tx_log.push_back(bus.bdc_data_in);
                sent_any = 1;
            end else begin
                chk("data_in_stable", 32'(bus.bdc_data_in), 32'(prev_data_in));
            end
            if (bus.bdc_read_data) begin
                read_cnt++;
                chk("read_engine_idle", eng_busy, 0);
                chk("read_one_cycle", 32'(prev_read), 0);
                chk("read_expected", 32'(pending != 0 && exp_tx.size() == 0 && exp_rx_left > 0), 1);
                if (exp_rx_left == exp_rx_total) begin
                    chk("read_delay_pulses", dpulses, DLY);
                    chk("read_delay_gap_ok", 32'(delay_started != 0 && cyc - last_pulse_cyc >= 1 && cyc - last_pulse_cyc <= 4), 1);
                end
                exp_rx_left--;
            end
            if (bus.rsp_valid) begin
                chk("rsp_expected", 32'(pending), 1);
                chk("rsp_work_left", 32'(exp_tx.size()) + 32'(exp_rx_left), 0);
                if (exp_err) begin
                    chk("illegal_latency_ok", 32'(cyc - acc_cyc >= 1 && cyc - acc_cyc <= 2), 1);
                    chk("illegal_no_send", sent_any, 0);
                end else if (exp_rx_total == 0) begin
                    chk("rsp_delay_pulses", dpulses, DLY);
                    chk("rsp_delay_gap_ok", 32'(delay_started != 0 && cyc - last_pulse_cyc >= 1 && cyc - last_pulse_cyc <= 3), 1);
                end
                exp_data = 16'h0000;
                if (exp_op == 1 && rx_log.size() >= 1) exp_data = {8'h00, rx_log[0]};
                if (exp_op == 3 && rx_log.size() >= 2) exp_data = {rx_log[0], rx_log[1]};
                chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
                chk("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
                held_rsp = exp_data;
                last_rsp_data = bus.rsp_data;
                last_rsp_err = bus.rsp_err;
                rsp_count++;
                pending = 0;
            end else if (pending == 0) begin
                chk("rsp_data_hold", 32'(bus.rsp_data), 32'(held_rsp));
            end else if (cyc == acc_cyc + 1) begin
                chk("rsp_data_cleared", 32'(bus.rsp_data), 0);
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                chk("accept_when_idle", pending, 0);
                pending = 1; acc_cyc = cyc; exp_op = int'(bus.cmd_op);
                sent_any = 0; delay_started = 0; dpulses = 0; last_pulse_cyc = cyc;
                exp_err = 1'b0; exp_rx_total = 0;
                rx_log.delete(); exp_tx.delete();
                exp_tx.push_back(bus.cmd_opcode);
                case (exp_op)
                    0: ;
                    1: begin exp_tx.push_back(bus.cmd_addr[15:8]); exp_tx.push_back(bus.cmd_addr[7:0]); exp_rx_total = 1; end
                    2: begin exp_tx.push_back(bus.cmd_addr[15:8]); exp_tx.push_back(bus.cmd_addr[7:0]);
                             exp_tx.push_back(bus.cmd_wdata[7:0]); end
                    3: exp_rx_total = 2;
                    4: begin exp_tx.push_back(bus.cmd_wdata[15:8]); exp_tx.push_back(bus.cmd_wdata[7:0]); end
                    default: begin exp_err = 1'b1; exp_tx.delete(); end
                endcase
                exp_rx_left = exp_rx_total;
            end
            prev_send = bus.bdc_send_data;
            prev_read = bus.bdc_read_data;
            prev_data_in = bus.bdc_data_in;
        end
    end

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] opc,
                            input logic [15:0] addr, input logic [15:0] wdata, input bit hold);
        bit got = 0;
        @(posedge clk); #1;
        bus.cmd_op = op; bus.cmd_opcode = opc; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin got = 1; break; end
        end
        if (!got) begin checks++; errors++; $display("FAIL accept_timeout op=%0d", op); end
        @(posedge clk); #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start);
        bit got = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (rsp_count != start) begin got = 1; break; end
        end
        if (!got) begin checks++; errors++; $display("FAIL rsp_timeout count=%0d", rsp_count); end
    endtask

    task automatic directed(input string nm, input logic [2:0] op, input logic [7:0] opc,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input int nbytes, input logic [31:0] bytes, input int nreads,
                            input logic [15:0] edata, input logic eerr);
        int start = rsp_count;
        int r0 = read_cnt;
        tx_log.delete();
        send_cmd(op, opc, addr, wdata, 0);
        wait_rsp(start);
        chk({nm, "_nbytes"}, tx_log.size(), nbytes);
        for (int i = 0; i < nbytes; i++)
            chk({nm, "_byte"}, (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF_FFFF,
                32'(bytes[31 - 8*i -: 8]));
        chk({nm, "_reads"}, read_cnt - r0, nreads);
        chk({nm, "_data"}, 32'(last_rsp_data), 32'(edata));
        chk({nm, "_err"}, 32'(last_rsp_err), 32'(eerr));
    endtask

    initial begin
        int start;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_opcode = '0;
        bus.cmd_addr = '0; bus.cmd_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        directed("nodata",  3'd0, 8'h90, 16'h0000, 16'h0000, 1, 32'h9000_0000, 0, 16'h0000, 1'b0);
        forced_rx.push_back(8'hA5);
        directed("read8",   3'd1, 8'hE0, 16'h1234, 16'h0000, 3, 32'hE012_3400, 1, 16'h00A5, 1'b0);
        directed("write8",  3'd2, 8'hC0, 16'h0080, 16'h005A, 4, 32'hC000_805A, 0, 16'h0000, 1'b0);
        forced_rx.push_back(8'h12); forced_rx.push_back(8'h34);
        directed("read16",  3'd3, 8'h6B, 16'h0000, 16'h0000, 1, 32'h6B00_0000, 2, 16'h1234, 1'b0);
        directed("illegal", 3'd7, 8'h11, 16'hFFFF, 16'hFFFF, 0, 32'h0, 0, 16'h0000, 1'b1);

        // reset during the delay of a READ8: no response, back to idle
        start = rsp_count;
        send_cmd(3'd1, 8'hE0, 16'h4321, 16'h0000, 0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (delay_started != 0 && dpulses >= 3) break;
        end
        chk("rst_reached_delay", 32'(delay_started != 0 && dpulses >= 3), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("rst_no_rsp", rsp_count, start);

        // back-to-back WRITE16 with cmd_valid held high
        start = rsp_count;
        tx_log.delete();
        send_cmd(3'd4, 8'h48, 16'h0000, 16'hBEEF, 1);
        send_cmd(3'd4, 8'h49, 16'h0000, 16'h0102, 0);
        chk("b2b_second_after_first_rsp", rsp_count - start, 1);
        wait_rsp(start + 1);
        chk("b2b_nbytes", tx_log.size(), 6);
        if (tx_log.size() == 6)
            chk("b2b_bytes", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h48BE_EF49);

        // randomized commands
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            start = rsp_count;
            send_cmd(3'($urandom_range(0, 7)), 8'($urandom), 16'($urandom), 16'($urandom), 0);
            wait_rsp(start);
        end
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog_expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bdm_command_sequencer.md
Name: bdm_command_sequencer

Overview:
- Sequences complete BDM commands over the byte-level BDC serial engine: opcode byte, optional address/data bytes, the mandatory target-clock delay, then optional read-back bytes.
- Sits between the host-side command source (UART/USB command decoder) and the BDC serial engine. It owns the engine's send_data/read_data strobes and the data_in byte.
- Returns one response per accepted command.

Parameters:
- DELAY_TCLKS, 16, number of tgt_clk_pulse events to wait after the last transmitted byte of any command (BDM no-ACK delay). Range 1..255.
- OPW, 3, width of cmd_op.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command request
- cmd_ready  out  1  high when the sequencer can accept a command (IDLE only)
- cmd_op  in  OPW  0 NODATA, 1 READ8, 2 WRITE8, 3 READ16, 4 WRITE16, 5..7 illegal
- cmd_opcode  in  8  BDM opcode byte, always sent first
- cmd_addr  in  16  target address (READ8/WRITE8 only), sent MSB byte first
- cmd_wdata  in  16  write data; WRITE8 uses [7:0], WRITE16 sends [15:8] then [7:0]
- rsp_valid  out  1  one-cycle pulse, response available
- rsp_data  out  16  read data; READ8 returns {8'h00,byte}, READ16 returns {first,second}; 0 for non-reads
- rsp_err  out  1  qualifies rsp_valid; set for an illegal cmd_op
- busy  out  1  high in every state except IDLE
- tgt_clk_pulse  in  1  one-cycle pulse per target BDC clock
- bdc_data_in  out  8  byte to the serial engine
- bdc_send_data  out  1  transmit-byte strobe
- bdc_read_data  out  1  receive-byte strobe
- bdc_data_out  in  8  received byte from the serial engine
- bdc_ready  in  1  serial engine idle; combinationally low while either strobe is high

Behaviour:
- Reset values: state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; busy=0; bdc_send_data=0; bdc_read_data=0; bdc_data_in=0; delay counter 0. The serial engine shares rst, so a reset mid-command abandons the command silently and produces no response.
- Accept: cmd_valid && cmd_ready in IDLE latches op, opcode, addr, wdata. The command builds a TX byte list:
  - NODATA: [opcode]
  - READ8: [opcode, addr hi, addr lo]
  - WRITE8: [opcode, addr hi, addr lo, wdata lo]
  - READ16: [opcode]
  - WRITE16: [opcode, wdata hi, wdata lo]
- RX count: READ8 = 1, READ16 = 2, all others = 0.
- Illegal op: go IDLE → RESP directly. rsp_err=1, rsp_data=0, nothing is sent on the serial engine.
- States:
  - IDLE: accepts a command as above.
  - TX_REQ: wait for bdc_ready=1. Then drive bdc_data_in with the current byte, pulse bdc_send_data for exactly one cycle, and go to TX_WAIT.
  - TX_WAIT: ignore bdc_ready in the first cycle after the strobe (guard). Then wait for bdc_ready=1. If more TX bytes remain, advance the index and go to TX_REQ; otherwise load the counter with DELAY_TCLKS and go to DELAY.
  - DELAY: decrement the counter on each tgt_clk_pulse. At 0, go to RX_REQ if RX count > 0, else go to RESP.
  - RX_REQ: wait for bdc_ready=1, pulse bdc_read_data for one cycle, and go to RX_WAIT.
  - RX_WAIT: apply the same guard cycle, then wait for bdc_ready=1. Shift bdc_data_out into rsp_data as rsp_data <= {rsp_data[7:0], bdc_data_out} and decrement the RX count. If the count is nonzero go to RX_REQ, else go to RESP.
  - RESP: rsp_valid=1 for one cycle, then go to IDLE.
- Strobes are never high in the same cycle. bdc_data_in is held stable from the strobe cycle until the next TX_REQ.
- rsp_data is cleared at command accept and holds its value after RESP until the next accept.
- Latency from accept to the first strobe is at most 2 clk cycles when bdc_ready is already high.
- cmd_valid asserted while busy is ignored. No queuing; the host must hold cmd_valid until cmd_ready.
- A tgt_clk_pulse in the cycle the counter is loaded is not counted.

Test Plan:
- NODATA opcode 8'h90, DELAY_TCLKS=16 → exactly one send strobe with data 8'h90; rsp_valid follows after 16 tgt_clk_pulse; rsp_err=0, rsp_data=0.
- READ8 opcode 8'hE0, addr 16'h1234, target returns 8'hA5 → sent bytes E0, 12, 34; then the delay; one read strobe; rsp_data=16'h00A5.
- WRITE8 opcode 8'hC0, addr 16'h0080, wdata 8'h5A → sent bytes C0, 00, 80, 5A; zero read strobes; rsp_valid after the delay.
- READ16 opcode 8'h6B, target returns 8'h12 then 8'h34 → rsp_data=16'h1234; two read strobes, each issued only after bdc_ready returns high.
- cmd_op=7 → rsp_valid with rsp_err=1 within 2 cycles; no strobes. In a separate run, assert rst during DELAY of a READ8 → all outputs return to reset values next cycle, no rsp_valid, cmd_ready=1.
- Back-to-back: cmd_valid held high across two WRITE16 commands → the second is accepted only after the first rsp_valid; bdc_send_data and bdc_read_data never overlap and never fire while bdc_ready=0.
